seq_scan_ctrl: RTL and testbench

Sequencing controller for the serial pattern-detector datapath. It accepts a parallel word over a valid/ready handshake and serializes it MSB-first, one bit per clock, through a programmable pattern matcher of 1–4 bits. It counts matches in overlapping or non-overlapping mode and returns the count over a second valid/ready handshake. It sits between a word-oriented producer and the bit-serial detection logic, replacing hand-driven testbench stimulus of the detector.

---
 rtl/seq_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit sequencing controller: serializes a captured word MSB-first through
// a 1..4 bit pattern matcher and returns the match count over a valid/ready handshake.
module seq_scan_ctrl #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              clear_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   input  logic [3:0]        pat,
   input  logic [2:0]        pat_len,
   input  logic              overlap,
   input  logic              abort,
   output logic              x,
   output logic              hit,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [1:0]        state
);

   localparam int BC_W = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WORD_W-1:0]   r_shift;
   logic [3:0]          r_hist;
   logic [2:0]          r_fill;
   logic [BC_W-1:0]     r_bitcnt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_hit;
   logic [3:0]          r_pat;
   logic [2:0]          r_len;
   logic                r_ovl;

   logic                w_accept;
   logic                w_last;
   logic                w_x;
   logic [2:0]          w_len_clamp;
   logic [3:0]          w_hist_nxt;
   logic [2:0]          w_fill_inc;
   logic [3:0]          w_mask;
   logic                w_match;

   always_comb begin
      w_len_clamp = pat_len;
      if (pat_len == 3'd0)
         w_len_clamp = 3'd1;
      else if (pat_len > 3'd4)
         w_len_clamp = 3'd4;
   end

   always_comb begin
      case (r_len)
         3'd1:    w_mask = 4'b0001;
         3'd2:    w_mask = 4'b0011;
         3'd3:    w_mask = 4'b0111;
         default: w_mask = 4'b1111;
      endcase
   end

   assign w_accept   = in_valid && (r_state == S_IDLE);
   assign w_last     = (r_bitcnt == BC_W'(WORD_W - 1));
   assign w_x        = (r_state == S_SCAN) && r_shift[WORD_W-1];
   assign w_hist_nxt = {r_hist[2:0], w_x};
   assign w_fill_inc = (r_fill >= 3'd4) ? 3'd4 : r_fill + 3'd1;
   // Match is judged on the history and fill as they will be after this edge.
   assign w_match    = (r_state == S_SCAN) && !abort && (w_fill_inc >= r_len) &&
                       ((w_hist_nxt & w_mask) == (r_pat & w_mask));

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_SCAN;
         S_SCAN: begin
            if (abort)
               w_state_nxt = S_IDLE;
            else if (w_last)
               w_state_nxt = S_DONE;
         end
         S_DONE: if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_shift  <= '0;
         r_hist   <= '0;
         r_fill   <= '0;
         r_bitcnt <= '0;
         r_cnt    <= '0;
         r_hit    <= 1'b0;
         r_pat    <= '0;
         r_len    <= 3'd1;
         r_ovl    <= 1'b0;
      end else begin
         r_hit <= 1'b0;
         if (w_accept) begin
            r_shift  <= in_word;
            r_pat    <= pat;
            r_len    <= w_len_clamp;
            r_ovl    <= overlap;
            r_hist   <= '0;
            r_fill   <= '0;
            r_bitcnt <= '0;
            r_cnt    <= '0;
         end else if (r_state == S_SCAN && !abort) begin
            r_shift  <= {r_shift[WORD_W-2:0], 1'b0};
            r_hist   <= w_hist_nxt;
            r_bitcnt <= r_bitcnt + BC_W'(1);
            // Non-overlapping mode restarts the fill so the next match needs fresh bits.
            r_fill   <= (w_match && !r_ovl) ? 3'd0 : w_fill_inc;
            r_hit    <= w_match;
            if (w_match && (r_cnt != '1))
               r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_SCAN);
   assign out_valid = (r_state == S_DONE);
   assign x         = w_x;
   assign hit       = r_hit;
   assign match_cnt = r_cnt;
   assign state     = r_state;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl: overlap/non-overlap counts,
// length clamp, output handshake back-pressure, abort and asynchronous clear.
module tb_seq_scan_ctrl;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 6;

   logic              clk = 1'b0;
   logic              clear_n;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_word;
   logic [3:0]        pat;
   logic [2:0]        pat_len;
   logic              overlap;
   logic              abort;
   logic              x;
   logic              hit;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  match_cnt;
   logic [1:0]        state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .clear_n   (clear_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .pat       (pat),
      .pat_len   (pat_len),
      .overlap   (overlap),
      .abort     (abort),
      .x         (x),
      .hit       (hit),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .match_cnt (match_cnt),
      .state     (state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Offer a word in IDLE and return #1 after the capture edge E0.
   task automatic capture(input logic [31:0] w, input logic [3:0] p, input logic [2:0] l,
                          input logic o);
      in_word  = w;
      pat      = p;
      pat_len  = l;
      overlap  = o;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      pat      = 4'b1111;
      pat_len  = 3'd4;
      overlap  = ~o;
      chk("capture_state", 32'(state), 32'd1);
      chk("capture_busy", 32'(busy), 32'd1);
   endtask

   // Run a full scan from just after E0; mask bit k-1 is the expected hit after E_k.
   task automatic scan_body(input logic [31:0] w, input logic [31:0] mask, input int expcnt);
      for (int k = 1; k <= WORD_W; k++) begin
         chk($sformatf("x_bit%0d", k), 32'(x), 32'(w[WORD_W-k]));
         @(posedge clk); #1;
         chk($sformatf("hit_E%0d", k), 32'(hit), 32'(mask[k-1]));
         if (k < WORD_W)
            chk($sformatf("ovalid_E%0d", k), 32'(out_valid), 32'd0);
      end
      chk("done_ovalid", 32'(out_valid), 32'd1);
      chk("done_state", 32'(state), 32'd2);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_inready", 32'(in_ready), 32'd0);
      chk("done_cnt", 32'(match_cnt), 32'(expcnt));
   endtask

   task automatic release_result(input int expcnt);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_state", 32'(state), 32'd0);
      chk("release_inready", 32'(in_ready), 32'd1);
      chk("release_cnt_hold", 32'(match_cnt), 32'(expcnt));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_inready"}, 32'(in_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
      chk({tag, "_hit"}, 32'(hit), 32'd0);
      chk({tag, "_x"}, 32'(x), 32'd0);
      chk({tag, "_cnt"}, 32'(match_cnt), 32'd0);
      chk({tag, "_state"}, 32'(state), 32'd0);
   endtask

   initial begin
      clear_n   = 1'b0;
      in_valid  = 1'b0;
      in_word   = '0;
      pat       = 4'b0;
      pat_len   = 3'd0;
      overlap   = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b0;
      #12;
      chk_reset_vals("reset");
      @(posedge clk); #1;
      clear_n = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals("post_reset");

      // Overlapping 101 scan: hits after E8, E10, E23, E25, E31.
      capture(32'hCD4C9ACA, 4'b0101, 3'd3, 1'b1);
      scan_body(32'hCD4C9ACA, 32'h4140_0280, 5);

      // Back-pressure in DONE with a second word waiting.
      in_word  = 32'hCD4C9ACA;
      pat      = 4'b0101;
      pat_len  = 3'd3;
      overlap  = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("hold_ovalid", 32'(out_valid), 32'd1);
         chk("hold_cnt", 32'(match_cnt), 32'd5);
         chk("hold_inready", 32'(in_ready), 32'd0);
         chk("hold_state", 32'(state), 32'd2);
      end
      release_result(5);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("second_capture_state", 32'(state), 32'd1);
      chk("second_capture_cnt", 32'(match_cnt), 32'd0);

      // Non-overlapping: hits after E8, E23, E31.
      scan_body(32'hCD4C9ACA, 32'h4040_0080, 3);
      release_result(3);

      // pat_len 0 treated as 1, matching every one bit.
      capture(32'hFFFF_FFFF, 4'b0001, 3'd0, 1'b1);
      scan_body(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
      release_result(32);

      // pat_len 7 treated as 4: pattern 1010 on alternating bits, overlapping.
      capture(32'hAAAA_AAAA, 4'b1010, 3'd7, 1'b1);
      scan_body(32'hAAAA_AAAA, 32'hAAAA_AAA8, 15);
      release_result(15);

      // Abort during the cycle after E12 of the overlap scan.
      capture(32'hCD4C9ACA, 4'b0101, 3'd3, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         chk("abort_run_ovalid", 32'(out_valid), 32'd0);
      end
      chk("abort_pre_cnt", 32'(match_cnt), 32'd2);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_cnt", 32'(match_cnt), 32'd2);
      chk("abort_hit", 32'(hit), 32'd0);
      chk("abort_ovalid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("abort_idle_ovalid", 32'(out_valid), 32'd0);
      chk("abort_idle_cnt", 32'(match_cnt), 32'd2);

      // Asynchronous clear between edges, mid-scan after some hits.
      capture(32'hCD4C9ACA, 4'b0101, 3'd3, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
      end
      chk("preclr_hit", 32'(hit), 32'd1);
      #2;
      clear_n = 1'b0;
      #1;
      chk_reset_vals("async_clr");
      #3;
      clear_n = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals("after_clr");
      capture(32'hCD4C9ACA, 4'b0101, 3'd3, 1'b0);
      scan_body(32'hCD4C9ACA, 32'h4040_0080, 3);
      release_result(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

endmodule
